// File: rtl/rf_write_arbiter_if.sv
// Request side of the register-file write arbiter: one valid/ready lane per
// writeback source, with destination index and data packed per requester.
interface rf_write_arbiter_if #(
   parameter int NumReq       = 3,
   parameter int AddressWidth = 5,
   parameter int dataWidth    = 32
);
   logic [NumReq-1:0]              req_valid;
   logic [NumReq-1:0]              req_ready;
   logic [NumReq*AddressWidth-1:0] req_addr;
   logic [NumReq*dataWidth-1:0]    req_data;

   modport master (
      output req_valid, req_addr, req_data,
      input  req_ready
   );

   modport slave (
      input  req_valid, req_addr, req_data,
      output req_ready
   );
endinterface

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the single register-file write port among the
// writeback sources; the winning write is registered for one cycle.
module rf_write_arbiter #(
   parameter int dataWidth    = 32,
   parameter int AddressWidth = 5,
   parameter int NumReq       = 3,
   localparam int IdWidth     = $clog2(NumReq)
) (
   input  logic                    Clk,
   input  logic                    reset,
   input  logic                    hold,
   rf_write_arbiter_if.slave       req,
   output logic                    RFwrite,
   output logic [AddressWidth-1:0] RegW,
   output logic [dataWidth-1:0]    dataW,
   output logic [IdWidth-1:0]      grant_id
);

   logic [IdWidth-1:0]      ptr;
   logic [IdWidth-1:0]      win;
   logic [IdWidth-1:0]      cand;
   logic [IdWidth-1:0]      nxt_ptr;
   logic                    found;
   logic                    xfer;
   logic [NumReq-1:0]       ready;
   logic [AddressWidth-1:0] win_addr;
   logic [dataWidth-1:0]    win_data;

   // Scan requesters starting at ptr; the first valid one wins.
   always_comb begin
      win   = '0;
      cand  = '0;
      found = 1'b0;
      ready = '0;
      for (int k = 0; k < NumReq; k++) begin
         cand = IdWidth'((int'(ptr) + k) % NumReq);
         if (!found && req.req_valid[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
      // Reset gating keeps req_ready low while reset is held.
      if (found && !hold && reset) begin
         ready[win] = 1'b1;
      end
   end

   assign req.req_ready = ready;
   assign xfer          = found & ~hold & reset;
   assign nxt_ptr       = (win == IdWidth'(NumReq - 1)) ? '0 : win + 1'b1;
   assign win_addr      = req.req_addr[win*AddressWidth +: AddressWidth];
   assign win_data      = req.req_data[win*dataWidth +: dataWidth];

   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) begin
         ptr      <= '0;
         RFwrite  <= 1'b0;
         RegW     <= '0;
         dataW    <= '0;
         grant_id <= '0;
      end else if (xfer) begin
         ptr      <= nxt_ptr;
         RegW     <= win_addr;
         dataW    <= win_data;
         grant_id <= win;
         // x0 writes complete the handshake but never reach the register file.
         RFwrite  <= |win_addr;
      end else begin
         RFwrite  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: stimulus pushes expected writes,
// a monitor pops and compares them after every observed handshake.
module tb_rf_write_arbiter;

   localparam int NR = 3;
   localparam int AW = 5;
   localparam int DW = 32;

   typedef struct {
      logic [1:0]    id;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          wr;
   } exp_t;

   logic          Clk = 1'b0;
   logic          reset = 1'b0;
   logic          hold = 1'b0;
   logic          RFwrite;
   logic [AW-1:0] RegW;
   logic [DW-1:0] dataW;
   logic [1:0]    grant_id;

   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t sb[$];

   rf_write_arbiter_if #(.NumReq(NR), .AddressWidth(AW), .dataWidth(DW)) bus ();

   rf_write_arbiter #(.dataWidth(DW), .AddressWidth(AW), .NumReq(NR)) dut (
      .Clk      (Clk),
      .reset    (reset),
      .hold     (hold),
      .req      (bus),
      .RFwrite  (RFwrite),
      .RegW     (RegW),
      .dataW    (dataW),
      .grant_id (grant_id)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic [1:0] id, input logic [AW-1:0] a, input logic [DW-1:0] d);
      exp_t e;
      e.id   = id;
      e.addr = a;
      e.data = d;
      e.wr   = (a != 0);
      sb.push_back(e);
   endtask

   task automatic set_req(input logic [NR-1:0] v, input logic [NR*AW-1:0] a,
                          input logic [NR*DW-1:0] d);
      bus.req_valid = v;
      bus.req_addr  = a;
      bus.req_data  = d;
   endtask

   // Monitor: a handshake seen at a rising edge must appear on the write port shortly after.
   initial begin
      logic          xfer;
      logic [NR-1:0] rdy;
      exp_t          e;
      forever begin
         @(posedge Clk);
         xfer = reset && ((bus.req_valid & bus.req_ready) != '0);
         rdy  = bus.req_ready;
         #2;
         if (xfer) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_xfer: ready=%b with empty scoreboard at %0t", rdy, $time);
            end else begin
               e = sb.pop_front();
               check("grant_onehot", 32'(rdy), 32'(3'b001 << e.id));
               check("RFwrite", 32'(RFwrite), 32'(e.wr));
               check("RegW", 32'(RegW), 32'(e.addr));
               check("dataW", dataW, e.data);
               check("grant_id", 32'(grant_id), 32'(e.id));
            end
         end
      end
   end

   localparam logic [NR*AW-1:0] ADDR_STD = {5'd3, 5'd2, 5'd1};
   localparam logic [NR*DW-1:0] DATA_STD = {32'hA2, 32'hA1, 32'hA0};

   initial begin
      set_req(3'b111, ADDR_STD, DATA_STD);

      // Reset held with every requester valid.
      @(negedge Clk);
      @(negedge Clk);
      #1;
      check("rst_ready", 32'(bus.req_ready), 32'h0);
      check("rst_RFwrite", 32'(RFwrite), 32'h0);
      check("rst_RegW", 32'(RegW), 32'h0);
      check("rst_dataW", dataW, 32'h0);
      check("rst_grant_id", 32'(grant_id), 32'h0);

      // Release: round robin 0,1,2,0,1,2 with everyone valid.
      @(negedge Clk);
      reset = 1'b1;
      #1;
      check("rel_ready", 32'(bus.req_ready), 32'h1);
      for (int i = 0; i < 6; i++) begin
         push(2'(i % 3), AW'((i % 3) + 1), 32'hA0 + 32'(i % 3));
      end
      repeat (6) @(negedge Clk);

      // Single write from requester 1; ptr is back at 0.
      set_req(3'b010, {5'd0, 5'd5, 5'd0}, {32'h0, 32'hDEADBEEF, 32'h0});
      #1;
      check("single_ready", 32'(bus.req_ready), 32'h2);
      push(2'd1, 5'd5, 32'hDEADBEEF);
      @(negedge Clk);

      // x0 write from requester 0 (ptr=2 wraps to 0), then ptr=1 favours requester 1.
      set_req(3'b001, {5'd0, 5'd0, 5'd0}, {32'h0, 32'h0, 32'h1234});
      #1;
      check("x0_ready", 32'(bus.req_ready), 32'h1);
      push(2'd0, 5'd0, 32'h1234);
      @(negedge Clk);
      set_req(3'b011, {5'd0, 5'd7, 5'd9}, {32'h0, 32'h77, 32'h55});
      #1;
      check("after_x0_ready", 32'(bus.req_ready), 32'h2);
      push(2'd1, 5'd7, 32'h77);
      push(2'd0, 5'd9, 32'h55);
      @(negedge Clk);
      bus.req_valid = 3'b001;
      @(negedge Clk);

      // Hold for three cycles with all valid; ptr stays at 1.
      set_req(3'b111, ADDR_STD, DATA_STD);
      hold = 1'b1;
      #1;
      check("hold_ready0", 32'(bus.req_ready), 32'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge Clk);
         #1;
         check("hold_ready", 32'(bus.req_ready), 32'h0);
         check("hold_RFwrite", 32'(RFwrite), 32'h0);
      end
      hold = 1'b0;
      #1;
      check("unhold_ready", 32'(bus.req_ready), 32'h2);
      push(2'd1, 5'd2, 32'hA1);
      push(2'd2, 5'd3, 32'hA2);
      push(2'd0, 5'd1, 32'hA0);
      @(negedge Clk);
      bus.req_valid = 3'b101;
      @(negedge Clk);
      bus.req_valid = 3'b001;
      @(negedge Clk);

      // Async reset between edges while a write is on the port.
      set_req(3'b010, {5'd0, 5'd5, 5'd0}, {32'h0, 32'hBEEF, 32'h0});
      push(2'd1, 5'd5, 32'hBEEF);
      @(posedge Clk);
      #4;
      reset = 1'b0;
      bus.req_valid = 3'b000;
      #1;
      check("async_RFwrite", 32'(RFwrite), 32'h0);
      check("async_RegW", 32'(RegW), 32'h0);
      check("async_dataW", dataW, 32'h0);
      @(negedge Clk);
      reset = 1'b1;
      set_req(3'b111, ADDR_STD, DATA_STD);
      #1;
      check("post_rst_ready", 32'(bus.req_ready), 32'h1);
      push(2'd0, 5'd1, 32'hA0);
      @(negedge Clk);
      bus.req_valid = 3'b000;
      repeat (3) @(negedge Clk);
      #1;
      check("idle_RFwrite", 32'(RFwrite), 32'h0);
      check("sb_drained", 32'(sb.size()), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: simulation exceeded time budget at %0t", $time);
      $fatal(1, "timeout");
   end

endmodule
